// File: rtl/sb_rx_frame_parser_if.sv
// Sideband receive parser bus: symbol input from the deserialiser, decoded
// AT/LT frames and status toward the register/AT handling logic.
// master = symbol source / frame consumer, slave = the parser.
interface sb_rx_frame_parser_if #(
    parameter int MAX_PAYLOAD = 4,
    parameter int ADDR_W      = 8
);
    logic [9:0]               sbrx;
    logic                     sym_valid;
    logic                     error;
    logic                     tconnect;
    logic                     tdisconnect;
    logic                     at_valid;
    logic                     at_is_cmd;
    logic [ADDR_W-1:0]        at_addr;
    logic                     at_write;
    logic [6:0]               at_len;
    logic [8*MAX_PAYLOAD-1:0] at_data;
    logic                     lt_valid;
    logic [7:0]               lt_lse;
    logic                     trans_error;
    logic                     disconnect;
    logic                     rx_busy;

    modport master (
        output sbrx, sym_valid, error, tconnect, tdisconnect,
        input  at_valid, at_is_cmd, at_addr, at_write, at_len, at_data,
               lt_valid, lt_lse, trans_error, disconnect, rx_busy
    );

    modport slave (
        input  sbrx, sym_valid, error, tconnect, tdisconnect,
        output at_valid, at_is_cmd, at_addr, at_write, at_len, at_data,
               lt_valid, lt_lse, trans_error, disconnect, rx_busy
    );
endinterface

// File: rtl/sb_rx_frame_parser.sv
// Sideband receive frame parser: decodes DLE STX .. DLE ETX AT frames (with DLE
// de-stuffing and length/count checks) and DLE LSE CLSE LT frames.
// Optional CRC-16 check of AT frames is enabled by defining SB_RX_CRC_CHECK_EN;
// without it the two trailing CRC bytes are counted but not checked.
module sb_rx_frame_parser #(
    parameter int MAX_PAYLOAD = 4,
    parameter int ADDR_W      = 8
) (
    input  logic                 sb_clk,
    input  logic                 rst,
    sb_rx_frame_parser_if.slave  bus
);
    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;
    localparam logic [7:0] LSE     = 8'h80;
    localparam logic [7:0] CLSE    = 8'h7F;

    // Byte counter covers addr + len + MAX_PAYLOAD data + 2 CRC (at most 131).
    localparam int              CNT_W     = 8;
    localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(MAX_PAYLOAD + 4);
    localparam logic [6:0]      LEN_MAX   = 7'(MAX_PAYLOAD);

    typedef enum logic [2:0] {S_DISC, S_IDLE, S_DLE1, S_AT, S_AT_DLE, S_LT} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q;
    logic                            is_cmd_q;
    logic [7:0]                      addr_q;
    logic [7:0]                      lenrw_q;
    logic [MAX_PAYLOAD-1:0][7:0]     data_q;
    logic [7:0]                      lse_q;

    logic                            at_valid_q, lt_valid_q, trans_err_q;
    logic                            at_is_cmd_q, at_write_q;
    logic [ADDR_W-1:0]               at_addr_q;
    logic [6:0]                      at_len_q;
    logic [MAX_PAYLOAD-1:0][7:0]     at_data_q;
    logic [7:0]                      lt_lse_q;

    logic [7:0]       b;
    logic             sym_err;
    logic             store_fault;
    logic [CNT_W-1:0] n_req;
    logic [CNT_W-1:0] data_idx;
    logic             data_we;
    logic             crc_ok;
    logic             store_en, start_frame, at_ok, lt_ok, err;

    assign b       = bus.sbrx[8:1];
    assign sym_err = bus.error | bus.sbrx[0] | ~bus.sbrx[9];

    // Data bytes are only carried by write commands and read responses.
    assign n_req = ((is_cmd_q & lenrw_q[7]) | (~is_cmd_q & ~lenrw_q[7]))
                   ? CNT_W'(lenrw_q[6:0]) : '0;

    // A byte about to be stored is illegal if the frame is already full or if it
    // is the len byte and announces more data than the buffer holds.
    assign store_fault = (cnt_q == MAX_BYTES) ||
                         (cnt_q == CNT_W'(1) && b[6:0] > LEN_MAX);

    assign data_idx = cnt_q - CNT_W'(2);
    assign data_we  = store_en && (cnt_q >= CNT_W'(2)) && (data_idx < n_req);

`ifdef SB_RX_CRC_CHECK_EN
    logic [15:0] crc_q, rx_crc_q;
    logic        crc_take;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++)
            x = x[15] ? ((x << 1) ^ 16'h8005) : (x << 1);
        return x;
    endfunction

    // Header and data bytes feed the CRC; everything after them is the received CRC.
    assign crc_take = (cnt_q < CNT_W'(2)) || (cnt_q < n_req + CNT_W'(2));

    // Running CRC from the STX byte on, plus a 2-byte window of the trailing bytes.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            crc_q    <= 16'hFFFF;
            rx_crc_q <= '0;
        end else if (start_frame) begin
            crc_q    <= crc16_byte(16'hFFFF, b);
            rx_crc_q <= '0;
        end else if (store_en) begin
            if (crc_take) crc_q    <= crc16_byte(crc_q, b);
            else          rx_crc_q <= {rx_crc_q[7:0], b};
        end
    end

    assign crc_ok = (crc_q == rx_crc_q);
`else
    assign crc_ok = 1'b1;
`endif

    // Next-state decode; tdisconnect wins over everything, tconnect is a link
    // event and does not need sym_valid.
    always_comb begin
        state_d     = state_q;
        store_en    = 1'b0;
        start_frame = 1'b0;
        at_ok       = 1'b0;
        lt_ok       = 1'b0;
        err         = 1'b0;
        if (bus.tdisconnect) begin
            state_d = S_DISC;
        end else if (state_q == S_DISC) begin
            if (bus.tconnect) state_d = S_IDLE;
        end else if (bus.sym_valid) begin
            if (sym_err) begin
                err     = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (b == DLE) state_d = S_DLE1;
                    S_DLE1: begin
                        if (b == STX_CMD || b == STX_RSP) begin
                            state_d     = S_AT;
                            start_frame = 1'b1;
                        end else if (b == LSE) state_d = S_LT;
                        else if (b == DLE)     state_d = S_DLE1;
                        else                   state_d = S_IDLE;
                    end
                    S_AT: begin
                        if (b == DLE) state_d = S_AT_DLE;
                        else if (store_fault) begin
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end else store_en = 1'b1;
                    end
                    S_AT_DLE: begin
                        state_d = S_IDLE;
                        if (b == DLE) begin
                            if (store_fault) err = 1'b1;
                            else begin
                                store_en = 1'b1;
                                state_d  = S_AT;
                            end
                        end else if (b == ETX) begin
                            if (cnt_q == n_req + CNT_W'(4) && crc_ok) at_ok = 1'b1;
                            else                                       err   = 1'b1;
                        end else err = 1'b1;
                    end
                    S_LT: begin
                        state_d = S_IDLE;
                        if (b == CLSE) lt_ok = 1'b1;
                        else           err   = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge sb_clk) begin
        if (rst) state_q <= S_DISC;
        else     state_q <= state_d;
    end

    // Frame assembly: header bytes, data lanes and the LSE seen on LT entry.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            cnt_q    <= '0;
            is_cmd_q <= 1'b0;
            addr_q   <= '0;
            lenrw_q  <= '0;
            data_q   <= '0;
            lse_q    <= '0;
        end else begin
            if (state_q == S_DLE1 && state_d == S_LT) lse_q <= b;
            if (start_frame) begin
                cnt_q    <= '0;
                is_cmd_q <= (b == STX_CMD);
                addr_q   <= '0;
                lenrw_q  <= '0;
                data_q   <= '0;
            end else if (store_en) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(0)) addr_q  <= b;
                if (cnt_q == CNT_W'(1)) lenrw_q <= b;
                for (int i = 0; i < MAX_PAYLOAD; i++)
                    if (data_we && data_idx == CNT_W'(i)) data_q[i] <= b;
            end
        end
    end

    // Registered pulses and result fields that hold until the next accepted frame.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            at_valid_q  <= 1'b0;
            lt_valid_q  <= 1'b0;
            trans_err_q <= 1'b0;
            at_is_cmd_q <= 1'b0;
            at_write_q  <= 1'b0;
            at_addr_q   <= '0;
            at_len_q    <= '0;
            at_data_q   <= '0;
            lt_lse_q    <= '0;
        end else begin
            at_valid_q  <= at_ok;
            lt_valid_q  <= lt_ok;
            trans_err_q <= err;
            if (at_ok) begin
                at_is_cmd_q <= is_cmd_q;
                at_write_q  <= lenrw_q[7];
                at_addr_q   <= ADDR_W'(addr_q);
                at_len_q    <= lenrw_q[6:0];
                at_data_q   <= data_q;
            end
            if (lt_ok) lt_lse_q <= lse_q;
        end
    end

    assign bus.at_valid    = at_valid_q;
    assign bus.at_is_cmd   = at_is_cmd_q;
    assign bus.at_addr     = at_addr_q;
    assign bus.at_write    = at_write_q;
    assign bus.at_len      = at_len_q;
    assign bus.at_data     = at_data_q;
    assign bus.lt_valid    = lt_valid_q;
    assign bus.lt_lse      = lt_lse_q;
    assign bus.trans_error = trans_err_q;
    assign bus.disconnect  = (state_q == S_DISC);
    assign bus.rx_busy     = (state_q == S_DLE1) || (state_q == S_AT) ||
                             (state_q == S_AT_DLE) || (state_q == S_LT);
endmodule

// File: tb/tb_sb_rx_frame_parser.sv
// Directed bench for sb_rx_frame_parser: a table of symbol sequences with
// expected pulses/fields, plus hand-written link and reset sequences.
module tb_sb_rx_frame_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sb_rx_frame_parser_if #(.MAX_PAYLOAD(4), .ADDR_W(8)) bus ();

    sb_rx_frame_parser #(.MAX_PAYLOAD(4), .ADDR_W(8)) dut (
        .sb_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [23:0][7:0] sym;
        logic [5:0]       n;
        logic [2:0]       xp;      // {at_valid, lt_valid, trans_error}
        logic             is_cmd;
        logic [7:0]       addr;
        logic             wr;
        logic [6:0]       len;
        logic [31:0]      data;
        logic [7:0]       lse;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic        m_is_cmd, m_wr;
    logic [7:0]  m_addr, m_lse;
    logic [6:0]  m_len;
    logic [31:0] m_data;

    vec_t       vecs[$];
    logic [7:0] qb[$];

    logic [2:0] pulses;
    assign pulses = {bus.at_valid, bus.lt_valid, bus.trans_error};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++)
            x = x[15] ? ((x << 1) ^ 16'h8005) : (x << 1);
        return x;
    endfunction

    function automatic vec_t at_frame(input logic [7:0] stx, input logic [7:0] addr,
                                      input logic [7:0] lenrw, input logic [31:0] data,
                                      input int nd, input logic flip, input logic [2:0] p);
        vec_t v;
        logic [7:0] pl[$];
        logic [15:0] c;
        int k;
        v = '0;
        pl.push_back(addr);
        pl.push_back(lenrw);
        for (int i = 0; i < nd; i++) pl.push_back(data[8*i +: 8]);
        c = crc16(16'hFFFF, stx);
        foreach (pl[i]) c = crc16(c, pl[i]);
        pl.push_back(c[15:8]);
        pl.push_back(c[7:0] ^ {7'b0, flip});
        k = 0;
        v.sym[k] = 8'hFE; k++;
        v.sym[k] = stx;   k++;
        foreach (pl[i]) begin
            v.sym[k] = pl[i]; k++;
            if (pl[i] == 8'hFE) begin v.sym[k] = 8'hFE; k++; end
        end
        v.sym[k] = 8'hFE; k++;
        v.sym[k] = 8'h40; k++;
        v.n      = 6'(k);
        v.xp     = p;
        v.is_cmd = (stx == 8'h05);
        v.addr   = addr;
        v.wr     = lenrw[7];
        v.len    = lenrw[6:0];
        v.data   = data;
        return v;
    endfunction

    function automatic vec_t raw(input logic [7:0] q[$], input logic [2:0] p);
        vec_t v;
        v = '0;
        foreach (q[i]) v.sym[i] = q[i];
        v.n   = 6'(q.size());
        v.xp  = p;
        v.lse = 8'h80;
        return v;
    endfunction

    task automatic tick(input logic [9:0] s, input logic v, input logic e,
                        input logic con, input logic dis);
        @(negedge clk);
        bus.sbrx        = s;
        bus.sym_valid   = v;
        bus.error       = e;
        bus.tconnect    = con;
        bus.tdisconnect = dis;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick({1'b1, b, 1'b0}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        tick(10'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic connect();
        tick(10'h200, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("connect_disc", bus.disconnect, 1'b0);
    endtask

    task automatic chk_fields();
        chk("at_is_cmd", bus.at_is_cmd, m_is_cmd);
        chk("at_addr",   bus.at_addr,   m_addr);
        chk("at_write",  bus.at_write,  m_wr);
        chk("at_len",    bus.at_len,    m_len);
        chk("at_data",   bus.at_data,   m_data);
        chk("lt_lse",    bus.lt_lse,    m_lse);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic spur;
        spur = 1'b0;
        for (int j = 0; j < int'(v.n) - 1; j++) begin
            send(v.sym[j]);
            if (pulses != 3'b000) spur = 1'b1;
        end
        send(v.sym[v.n - 1]);
        chk($sformatf("v%0d_pulses", id), pulses, v.xp);
        chk($sformatf("v%0d_early_pulse", id), spur, 1'b0);
        if (v.xp[2]) begin
            m_is_cmd = v.is_cmd; m_addr = v.addr; m_wr = v.wr;
            m_len = v.len; m_data = v.data;
        end
        if (v.xp[1]) m_lse = v.lse;
        chk_fields();
        idle();
        chk($sformatf("v%0d_pulse_width", id), pulses, 3'b000);
    endtask

    initial begin
        logic [2:0] crc_bad_exp;
`ifdef SB_RX_CRC_CHECK_EN
        crc_bad_exp = 3'b001;
`else
        crc_bad_exp = 3'b100;
`endif
        vecs.push_back(at_frame(8'h05, 8'h12, 8'h82, 32'h0000BBAA, 2, 1'b0, 3'b100));
        vecs.push_back(at_frame(8'h05, 8'hFE, 8'h83, 32'h002211FE, 3, 1'b0, 3'b100));
        vecs.push_back(at_frame(8'h04, 8'h34, 8'h04, 32'h04030201, 4, 1'b0, 3'b100));
        vecs.push_back(at_frame(8'h05, 8'h56, 8'h03, 32'h0,        0, 1'b0, 3'b100));
        vecs.push_back(at_frame(8'h04, 8'h78, 8'h81, 32'h0,        0, 1'b0, 3'b100));
        qb = '{8'hFE, 8'h80, 8'h7F};               vecs.push_back(raw(qb, 3'b010));
        qb = '{8'hFE, 8'h80, 8'h33};               vecs.push_back(raw(qb, 3'b001));
        vecs.push_back(at_frame(8'h05, 8'h12, 8'h82, 32'h0000BBAA, 2, 1'b1, crc_bad_exp));
        qb = '{8'hFE, 8'h05, 8'h12, 8'h85};        vecs.push_back(raw(qb, 3'b001));
        vecs.push_back(at_frame(8'h05, 8'h12, 8'h02, 32'h00000011, 1, 1'b0, 3'b001));
        qb = '{8'hFE, 8'h05, 8'h12, 8'hFE, 8'h33}; vecs.push_back(raw(qb, 3'b001));
        qb = '{8'hFE, 8'h05, 8'h12, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07};               vecs.push_back(raw(qb, 3'b001));
        qb = '{8'hFE, 8'h22, 8'hFE, 8'hFE, 8'h80, 8'h7F}; vecs.push_back(raw(qb, 3'b010));
        vecs.push_back(at_frame(8'h04, 8'h9A, 8'h82, 32'h00002211, 2, 1'b0, 3'b001));

        m_is_cmd = 1'b0; m_wr = 1'b0; m_addr = '0; m_lse = '0; m_len = '0; m_data = '0;
        bus.sbrx = 10'h200; bus.sym_valid = 1'b0; bus.error = 1'b0;
        bus.tconnect = 1'b0; bus.tdisconnect = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disconnect", bus.disconnect, 1'b1);
        chk("rst_busy",       bus.rx_busy,    1'b0);
        chk("rst_pulses",     pulses,         3'b000);
        chk_fields();
        @(negedge clk);
        rst = 1'b0;

        // Symbols are ignored while disconnected.
        send(8'hFE); send(8'h80); send(8'h7F);
        chk("disc_ignore_pulses", pulses, 3'b000);
        chk("disc_ignore_state",  bus.disconnect, 1'b1);
        connect();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Lower-layer error flag mid-frame.
        send(8'hFE); send(8'h05);
        tick({1'b1, 8'h12, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("error_flag", pulses, 3'b001);
        // Bad stop bit inside DLE1, bad start bit in IDLE.
        send(8'hFE);
        chk("busy_dle1", bus.rx_busy, 1'b1);
        tick({1'b0, 8'h05, 1'b0}, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bad_stop", pulses, 3'b001);
        chk("busy_after_err", bus.rx_busy, 1'b0);
        tick({1'b1, 8'hFE, 1'b1}, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bad_start_idle", pulses, 3'b001);
        idle();

        // tdisconnect during data phase, then a clean frame after reconnect.
        send(8'hFE); send(8'h05); send(8'h12); send(8'h82); send(8'hAA);
        tick({1'b1, 8'hBB, 1'b0}, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tdisc_data_pulses", pulses, 3'b000);
        chk("tdisc_data_state",  bus.disconnect, 1'b1);
        send(8'hFE); send(8'h40);
        chk("tdisc_rest_pulses", pulses, 3'b000);
        connect();
        run_vec(100, vecs[0]);

        // tdisconnect beats frame completion on the ETX symbol.
        for (int j = 0; j < int'(vecs[0].n) - 1; j++) send(vecs[0].sym[j]);
        tick({1'b1, 8'h40, 1'b0}, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tdisc_etx_pulses", pulses, 3'b000);
        chk("tdisc_etx_state",  bus.disconnect, 1'b1);
        idle();
        chk("tdisc_etx_late", pulses, 3'b000);
        connect();

        // tdisconnect beats a symbol error.
        send(8'hFE);
        tick({1'b1, 8'h05, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("tdisc_err_pulses", pulses, 3'b000);
        chk("tdisc_err_state",  bus.disconnect, 1'b1);
        connect();

        // Reset mid-frame drops the frame and clears held results.
        send(8'hFE); send(8'h05); send(8'h12);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_is_cmd = 1'b0; m_wr = 1'b0; m_addr = '0; m_lse = '0; m_len = '0; m_data = '0;
        chk("rst_mid_pulses", pulses, 3'b000);
        chk("rst_mid_disc",   bus.disconnect, 1'b1);
        chk_fields();
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("rst_mid_after", pulses, 3'b000);
        connect();
        run_vec(101, vecs[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
